// File: rtl/operadores_seq_if.sv
// Handshake/data bundle for operadores_seq.
// The master side drives operands and the consumer ready. The slave side (the
// operator block) drives in_ready, out_valid and the three results.
interface operadores_seq_if #(
    parameter int W   = 6,
    parameter int REP = 3
);
    localparam int SW = ($clog2(W) < 1) ? 1 : $clog2(W);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     dataa;
    logic [W-1:0]     datab;
    logic [1:0]       mode;
    logic [SW-1:0]    shamt;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out1;
    logic [REP*W-1:0] out2;
    logic [W-1:0]     out3;

    modport master (
        output in_valid, dataa, datab, mode, shamt, out_ready,
        input  in_ready, out_valid, out1, out2, out3
    );

    modport slave (
        input  in_valid, dataa, datab, mode, shamt, out_ready,
        output in_ready, out_valid, out1, out2, out3
    );
endinterface

// File: rtl/operadores_seq.sv
// operadores_seq: sequential concatenation / replication / shift example.
// temp = {dataa[H-1:0], datab[H-1:0]}; out1 = temp, out2 = {REP{temp}},
// out3 = temp shifted or rotated by mode/shamt.
// Default build shifts serially, one bit per cycle in the SHIFT state.
// Defining OPERADORES_BARREL_EN replaces that with a combinational barrel
// shifter evaluated in the accept cycle, so the FSM goes IDLE -> HOLD directly.
// Mode: 00 shl logical, 01 shr logical, 10 rotate left, 11 shr arithmetic.
module operadores_seq #(
    parameter int W   = 6,
    parameter int REP = 3
) (
    input  logic clk,
    input  logic reset_n,
    operadores_seq_if.slave bus
);
    localparam int H  = W / 2;
    localparam int SW = ($clog2(W) < 1) ? 1 : $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state_q;
    state_t           state_d;
    logic             out_valid_q;
    logic [W-1:0]     out1_q;
    logic [REP*W-1:0] out2_q;
    logic [W-1:0]     out3_q;
    logic [W-1:0]     temp;
    logic             accept;
    logic             unused_hi;

`ifndef OPERADORES_BARREL_EN
    logic [1:0]       mode_q;
    logic [SW-1:0]    cnt_q;

    // One serial step of the selected shift/rotate operation.
    function automatic logic [W-1:0] step1(input logic [W-1:0] v, input logic [1:0] m);
        logic [W-1:0] r;
        case (m)
            2'b00:   r = {v[W-2:0], 1'b0};
            2'b01:   r = {1'b0, v[W-1:1]};
            2'b10:   r = {v[W-2:0], v[W-1]};
            default: r = {v[W-1], v[W-1:1]};
        endcase
        return r;
    endfunction
`else
    // Whole shift in one go; amounts >= W behave exactly like repeated steps.
    function automatic logic [W-1:0] barrel(input logic [W-1:0] v, input logic [1:0] m,
                                            input logic [SW-1:0] s);
        logic [W-1:0] r;
        int           amt;
        int           k;
        amt = int'(s);
        k   = amt % W;
        case (m)
            2'b00:   r = (amt >= W) ? '0 : (v << amt);
            2'b01:   r = (amt >= W) ? '0 : (v >> amt);
            2'b10:   r = (k == 0) ? v : ((v << k) | (v >> (W - k)));
            default: r = (amt >= W) ? {W{v[W-1]}} : W'($signed(v) >>> amt);
        endcase
        return r;
    endfunction
`endif

    assign temp          = {bus.dataa[H-1:0], bus.datab[H-1:0]};
    assign accept        = bus.in_valid && (state_q == IDLE);
    assign unused_hi     = ^{bus.dataa[W-1:H], bus.datab[W-1:H]};
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out1      = out1_q;
    assign bus.out2      = out2_q;
    assign bus.out3      = out3_q;

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, step in SHIFT until the counter empties, wait for the consumer in HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef OPERADORES_BARREL_EN
                    state_d = HOLD;
`else
                    state_d = (bus.shamt != '0) ? SHIFT : HOLD;
`endif
                end
            end
`ifndef OPERADORES_BARREL_EN
            SHIFT: begin
                if (cnt_q == SW'(1)) begin
                    state_d = HOLD;
                end
            end
`endif
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, shift out3 in SHIFT, raise out_valid one cycle into HOLD.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out1_q      <= '0;
            out2_q      <= '0;
            out3_q      <= '0;
`ifndef OPERADORES_BARREL_EN
            mode_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (accept) begin
                        out1_q <= temp;
                        out2_q <= {REP{temp}};
`ifdef OPERADORES_BARREL_EN
                        out3_q <= barrel(temp, bus.mode, bus.shamt);
`else
                        out3_q <= temp;
                        mode_q <= bus.mode;
                        cnt_q  <= bus.shamt;
`endif
                    end
                end
`ifndef OPERADORES_BARREL_EN
                SHIFT: begin
                    out3_q <= step1(out3_q, mode_q);
                    cnt_q  <= cnt_q - SW'(1);
                end
`endif
                HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: out_valid_q <= 1'b0;
            endcase
        end
    end
endmodule
